// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver : N-digit multiplexed 7-segment driver with a sequential
//                    double-dabble converter, leading-zero blanking and overflow dash.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
   parameter int N_DIGITS        = 2,
   parameter int BIN_W           = 8,
   parameter int SCAN_DIV        = 27000,
   parameter int ACTIVE_HIGH_SEG = 1,
   parameter int ACTIVE_HIGH_DIG = 1,
   parameter int LZ_BLANK        = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [BIN_W-1:0]    value,
   output logic                busy,
   output logic                ovf,
   output logic [6:0]          seg,
   output logic [N_DIGITS-1:0] dig
);

   localparam int BCD_W  = 4 * N_DIGITS;
   localparam int STEP_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DIG_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [6:0] SEG_ZERO  = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;

   localparam logic [N_DIGITS-1:0] DIG0_RAW = N_DIGITS'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_CONV = 1'b1
   } state_t;

   state_t              state_q,    state_d;
   logic [STEP_W-1:0]   step_q,     step_d;
   logic [BCD_W-1:0]    bcd_q,      bcd_d;
   logic [BIN_W-1:0]    shift_q,    shift_d;
   logic                sticky_q,   sticky_d;
   logic [BCD_W-1:0]    buf_q,      buf_d;
   logic                ovf_q,      ovf_d;
   logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
   logic [DIG_W-1:0]    dig_idx_q,  dig_idx_d;
   logic [6:0]          seg_q,      seg_d;
   logic [N_DIGITS-1:0] dig_q,      dig_d;

   logic [BCD_W-1:0]    bcd_adj;
   logic [BCD_W-1:0]    bcd_shift;
   logic [BIN_W-1:0]    shift_next;
   logic                carry_out;
   logic                step_last;
   logic                scan_wrap;
   logic [N_DIGITS-1:0] dig_raw;

   function automatic logic [6:0] encode_bcd(input logic [3:0] nib);
      logic [6:0] p;
      case (nib)
         4'd0:    p = 7'b1111110;
         4'd1:    p = 7'b0110000;
         4'd2:    p = 7'b1101101;
         4'd3:    p = 7'b1111001;
         4'd4:    p = 7'b0110011;
         4'd5:    p = 7'b1011011;
         4'd6:    p = 7'b1011111;
         4'd7:    p = 7'b1110000;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1111011;
         default: p = SEG_BLANK;
      endcase
      return p;
   endfunction

   // A digit is a leading zero when it and every more significant digit are zero.
   function automatic logic [6:0] digit_pattern(input logic [DIG_W-1:0] idx,
                                                input logic [BCD_W-1:0] bcd,
                                                input logic             ovf_flag);
      logic       upper_zero;
      logic [3:0] nib;
      logic [6:0] p;
      upper_zero = 1'b1;
      nib        = 4'd0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (i >= int'(idx)) upper_zero = upper_zero & (bcd[4*i +: 4] == 4'd0);
         if (i == int'(idx)) nib = bcd[4*i +: 4];
      end
      if (ovf_flag)
         p = SEG_DASH;
      else if ((LZ_BLANK != 0) && (idx != '0) && upper_zero)
         p = SEG_BLANK;
      else
         p = encode_bcd(nib);
      return (ACTIVE_HIGH_SEG != 0) ? p : ~p;
   endfunction

   // One double-dabble step: add 3 to nibbles >= 5, then shift left through the BCD.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      {carry_out, bcd_shift, shift_next} = {bcd_adj, shift_q, 1'b0};
   end

   assign step_last = (step_q == STEP_W'(BIN_W - 1));

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      bcd_d    = bcd_q;
      shift_d  = shift_q;
      sticky_d = sticky_q;
      buf_d    = buf_q;
      ovf_d    = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d  = ST_CONV;
               step_d   = '0;
               bcd_d    = '0;
               shift_d  = value;
               sticky_d = 1'b0;
            end
         end
         ST_CONV: begin
            bcd_d    = bcd_shift;
            shift_d  = shift_next;
            sticky_d = sticky_q | carry_out;
            step_d   = step_q + STEP_W'(1);
            if (step_last) begin
               state_d = ST_IDLE;
               buf_d   = bcd_shift;
               ovf_d   = sticky_q | carry_out;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Segment pattern is latched only at slot boundaries so a digit never changes mid-slot.
   assign scan_wrap = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));

   always_comb begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      dig_idx_d  = dig_idx_q;
      seg_d      = seg_q;
      dig_d      = dig_q;
      dig_raw    = '0;
      if (scan_wrap) begin
         scan_cnt_d = '0;
         if (dig_idx_q == DIG_W'(N_DIGITS - 1))
            dig_idx_d = '0;
         else
            dig_idx_d = dig_idx_q + DIG_W'(1);
         for (int i = 0; i < N_DIGITS; i++) dig_raw[i] = (int'(dig_idx_d) == i);
         dig_d = (ACTIVE_HIGH_DIG != 0) ? dig_raw : ~dig_raw;
         seg_d = digit_pattern(dig_idx_d, buf_q, ovf_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         step_q     <= '0;
         bcd_q      <= '0;
         shift_q    <= '0;
         sticky_q   <= 1'b0;
         buf_q      <= '0;
         ovf_q      <= 1'b0;
         scan_cnt_q <= '0;
         dig_idx_q  <= '0;
         seg_q      <= (ACTIVE_HIGH_SEG != 0) ? SEG_ZERO : ~SEG_ZERO;
         dig_q      <= (ACTIVE_HIGH_DIG != 0) ? DIG0_RAW : ~DIG0_RAW;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         bcd_q      <= bcd_d;
         shift_q    <= shift_d;
         sticky_q   <= sticky_d;
         buf_q      <= buf_d;
         ovf_q      <= ovf_d;
         scan_cnt_q <= scan_cnt_d;
         dig_idx_q  <= dig_idx_d;
         seg_q      <= seg_d;
         dig_q      <= dig_d;
      end
   end

   assign busy = (state_q == ST_CONV);
   assign ovf  = ovf_q;
   assign seg  = seg_q;
   assign dig  = dig_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// tb_seg7_scan_driver : directed bench for seg7_scan_driver (default, no-blank
//                       and inverted-polarity instances sharing one stimulus).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

   logic       clk;
   logic       rst_n;
   logic       load;
   logic [7:0] value;

   logic       busy_a, ovf_a, busy_b, ovf_b, busy_c, ovf_c;
   logic [6:0] seg_a, seg_b, seg_c;
   logic [1:0] dig_a, dig_b, dig_c;

   int checks   = 0;
   int failures = 0;

   seg7_scan_driver #(.N_DIGITS(2), .BIN_W(8), .SCAN_DIV(4),
                      .ACTIVE_HIGH_SEG(1), .ACTIVE_HIGH_DIG(1), .LZ_BLANK(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value),
      .busy(busy_a), .ovf(ovf_a), .seg(seg_a), .dig(dig_a));

   seg7_scan_driver #(.N_DIGITS(2), .BIN_W(8), .SCAN_DIV(4),
                      .ACTIVE_HIGH_SEG(1), .ACTIVE_HIGH_DIG(1), .LZ_BLANK(0)) u_dut_nlz (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value),
      .busy(busy_b), .ovf(ovf_b), .seg(seg_b), .dig(dig_b));

   seg7_scan_driver #(.N_DIGITS(2), .BIN_W(8), .SCAN_DIV(4),
                      .ACTIVE_HIGH_SEG(0), .ACTIVE_HIGH_DIG(0), .LZ_BLANK(1)) u_dut_inv (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value),
      .busy(busy_c), .ovf(ovf_c), .seg(seg_c), .dig(dig_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      load  = 1'b1;
      value = v;
      tick();
      load  = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy_a === 1'b1 && n < 40) begin
         n++;
         tick();
      end
   endtask

   // Returns the segment bus of instance sel during the first cycle its dig equals pat.
   task automatic get_slot(input int sel, input logic [1:0] pat,
                           output logic [6:0] s, output bit ok);
      logic [1:0] d;
      ok = 1'b0;
      s  = 7'h00;
      for (int n = 0; n < 32 && !ok; n++) begin
         d = (sel == 0) ? dig_a : (sel == 1) ? dig_b : dig_c;
         if (d === pat) begin
            s  = (sel == 0) ? seg_a : (sel == 1) ? seg_b : seg_c;
            ok = 1'b1;
         end else begin
            tick();
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load  = 1'b0;
      value = 8'd0;
      repeat (3) tick();
      rst_n = 1'b1;
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
      checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf_a); end
      checks++; if (dig_a !== 2'b01) begin failures++; $display("FAIL reset_dig: got %b expected 01", dig_a); end
      checks++; if (seg_a !== 7'b1111110) begin failures++; $display("FAIL reset_seg: got %b expected 1111110", seg_a); end
      checks++; if (dig_c !== 2'b10) begin failures++; $display("FAIL reset_dig_inv: got %b expected 10", dig_c); end
      checks++; if (seg_c !== 7'b0000001) begin failures++; $display("FAIL reset_seg_inv: got %b expected 0000001", seg_c); end
   endtask

   task automatic test_conversion();
      int         n;
      bit         synced;
      logic [1:0] prev;
      logic [1:0] exp_dig;
      logic [6:0] exp_seg;
      do_load(8'd42);
      wait_idle(n);
      checks++; if (n != 8) begin failures++; $display("FAIL conv_busy_cycles: got %0d expected 8", n); end
      checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL conv_ovf: got %b expected 0", ovf_a); end
      repeat (10) tick();
      synced = 1'b0;
      prev   = dig_a;
      for (int i = 0; i < 20 && !synced; i++) begin
         tick();
         if (prev === 2'b10 && dig_a === 2'b01) synced = 1'b1;
         prev = dig_a;
      end
      checks++;
      if (!synced) begin
         failures++;
         $display("FAIL conv_scan_sync: got no 10->01 dig transition expected one within 20 cycles");
      end else begin
         for (int j = 0; j < 8; j++) begin
            exp_dig = (j < 4) ? 2'b01 : 2'b10;
            exp_seg = (j < 4) ? 7'b1101101 : 7'b0110011;
            checks++;
            if (dig_a !== exp_dig || seg_a !== exp_seg) begin
               failures++;
               $display("FAIL conv_scan_cycle%0d: got dig=%b seg=%b expected dig=%b seg=%b",
                        j, dig_a, seg_a, exp_dig, exp_seg);
            end
            tick();
         end
      end
   endtask

   task automatic test_lz_blank();
      int         n;
      logic [6:0] s;
      bit         ok;
      do_load(8'd7);
      wait_idle(n);
      repeat (10) tick();
      get_slot(0, 2'b01, s, ok);
      checks++; if (!ok || s !== 7'b1110000) begin failures++; $display("FAIL lz_dig0: got %b (found=%0d) expected 1110000", s, ok); end
      get_slot(0, 2'b10, s, ok);
      checks++; if (!ok || s !== 7'b0000000) begin failures++; $display("FAIL lz_dig1_blank: got %b (found=%0d) expected 0000000", s, ok); end
      get_slot(1, 2'b10, s, ok);
      checks++; if (!ok || s !== 7'b1111110) begin failures++; $display("FAIL nolz_dig1: got %b (found=%0d) expected 1111110", s, ok); end
      get_slot(1, 2'b01, s, ok);
      checks++; if (!ok || s !== 7'b1110000) begin failures++; $display("FAIL nolz_dig0: got %b (found=%0d) expected 1110000", s, ok); end
   endtask

   task automatic test_overflow();
      int         n;
      logic [6:0] s;
      bit         ok;
      do_load(8'd100);
      wait_idle(n);
      checks++; if (ovf_a !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", ovf_a); end
      repeat (10) tick();
      get_slot(0, 2'b01, s, ok);
      checks++; if (!ok || s !== 7'b0000001) begin failures++; $display("FAIL ovf_dig0_dash: got %b (found=%0d) expected 0000001", s, ok); end
      get_slot(0, 2'b10, s, ok);
      checks++; if (!ok || s !== 7'b0000001) begin failures++; $display("FAIL ovf_dig1_dash: got %b (found=%0d) expected 0000001", s, ok); end
      do_load(8'd99);
      wait_idle(n);
      checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", ovf_a); end
      repeat (10) tick();
      get_slot(0, 2'b01, s, ok);
      checks++; if (!ok || s !== 7'b1111011) begin failures++; $display("FAIL n99_dig0: got %b (found=%0d) expected 1111011", s, ok); end
      get_slot(0, 2'b10, s, ok);
      checks++; if (!ok || s !== 7'b1111011) begin failures++; $display("FAIL n99_dig1: got %b (found=%0d) expected 1111011", s, ok); end
   endtask

   task automatic test_busy_drop();
      int         n;
      logic [6:0] s;
      bit         ok;
      do_load(8'd42);
      tick();
      do_load(8'd13);
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL drop_busy_k2: got %b expected 1", busy_a); end
      wait_idle(n);
      checks++; if (n != 6) begin failures++; $display("FAIL drop_remaining_cycles: got %0d expected 6", n); end
      repeat (10) tick();
      get_slot(0, 2'b01, s, ok);
      checks++; if (!ok || s !== 7'b1101101) begin failures++; $display("FAIL drop_dig0: got %b (found=%0d) expected 1101101", s, ok); end
      get_slot(0, 2'b10, s, ok);
      checks++; if (!ok || s !== 7'b0110011) begin failures++; $display("FAIL drop_dig1: got %b (found=%0d) expected 0110011", s, ok); end
      // Back-to-back: a second load at edge k+9 is accepted.
      do_load(8'd60);
      repeat (7) tick();
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL b2b_busy_k7: got %b expected 1", busy_a); end
      tick();
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_busy_k8: got %b expected 0", busy_a); end
      do_load(8'd13);
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL b2b_accept_k9: got %b expected 1", busy_a); end
      wait_idle(n);
      repeat (10) tick();
      get_slot(0, 2'b01, s, ok);
      checks++; if (!ok || s !== 7'b1111001) begin failures++; $display("FAIL b2b_dig0: got %b (found=%0d) expected 1111001", s, ok); end
      get_slot(0, 2'b10, s, ok);
      checks++; if (!ok || s !== 7'b0110000) begin failures++; $display("FAIL b2b_dig1: got %b (found=%0d) expected 0110000", s, ok); end
   endtask

   task automatic test_reset_mid_conv();
      logic [6:0] s;
      bit         ok;
      do_load(8'd55);
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      checks++; if (busy_c !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy_c); end
      checks++; if (ovf_c !== 1'b0) begin failures++; $display("FAIL midrst_ovf: got %b expected 0", ovf_c); end
      checks++; if (dig_c !== 2'b10) begin failures++; $display("FAIL midrst_dig_inv: got %b expected 10", dig_c); end
      checks++; if (seg_c !== 7'b0000001) begin failures++; $display("FAIL midrst_seg_inv: got %b expected 0000001", seg_c); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL midrst_busy_main: got %b expected 0", busy_a); end
      rst_n = 1'b1;
      get_slot(2, 2'b01, s, ok);
      checks++; if (!ok || s !== 7'b1111111) begin failures++; $display("FAIL midrst_dig1_blank_inv: got %b (found=%0d) expected 1111111", s, ok); end
      get_slot(2, 2'b10, s, ok);
      checks++; if (!ok || s !== 7'b0000001) begin failures++; $display("FAIL midrst_dig0_zero_inv: got %b (found=%0d) expected 0000001", s, ok); end
   endtask

   initial begin
      test_reset();
      test_conversion();
      test_lz_blank();
      test_overflow();
      test_busy_drop();
      test_reset_mid_conv();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
